i2s_rx_ctrl: RTL
================

Name: i2s_rx_ctrl

Overview:
I2S master receive controller for the SoC's microphone path.
- Generates the I2S bit clock and word select from HCLK.
- Captures one selected channel's samples from the serial input pin and buffers them in a small FIFO with a valid/ready pop interface.
- Sits between the pad-level I2S pins and the SoC bus-slave or DSP consumer that drains samples.

Parameters:
- CLK_DIV, 4: HCLK cycles per SCK half-period; legal range is 3 or more.
- FRAME_BITS, 32: SCK cycles per channel slot.
- SAMPLE_W, 24: bits captured per sample, MSB first; must be FRAME_BITS-1 or less.
- FIFO_DEPTH, 8: sample FIFO entries; must be a power of two.
- CHANNEL, 0: captured slot; 0 = left (ws low), 1 = right (ws high).

Ports:
- HCLK  in  1  system clock.
- HRESETn  in  1  asynchronous active-low reset.
- en  in  1  run enable.
- sd  in  1  serial data from pad; asynchronous to HCLK.
- sck  out  1  I2S bit clock.
- ws  out  1  I2S word select.
- sample_data  out  SAMPLE_W  FIFO head.
- sample_valid  out  1  FIFO not empty.
- sample_ready  in  1  consumer pop.
- fifo_level  out  clog2(FIFO_DEPTH)+1  entries held.
- overrun  out  1  sticky overrun flag.
- clr_overrun  in  1  clears overrun.

Behaviour:
- Clock and reset: one clock, HCLK. HRESETn is asynchronous assert, active low. Reset values: sck=0, ws=0, sample_valid=0, sample_data=0, fifo_level=0, overrun=0, state=IDLE, all counters 0.
- Input sync: sd passes through a 2-flop synchronizer; all capture uses the synchronized value.
- SCK divider:
  - Counter runs 0..CLK_DIV-1 and toggles sck at terminal count.
  - rise_evt is the HCLK cycle sck goes 0->1; fall_evt is the cycle sck goes 1->0.
  - SCK period = 2*CLK_DIV HCLK.
- Framing:
  - Bit counter 0..FRAME_BITS-1 advances on each fall_evt.
  - ws toggles on the fall_evt that wraps the bit counter, so ws changes only on SCK falling edges.
- Capture (Philips I2S, 1-bit delay):
  - Sampling happens on fall_evt, i.e. the end of the SCK high phase. This needs CLK_DIV of 3 or more so synchronizer latency stays inside the high phase.
  - Slot bit 0 is the delay bit and is ignored.
  - Slot bits 1..SAMPLE_W shift MSB-first into the shift register. Bits SAMPLE_W+1 and above are ignored.
  - A push is issued on the fall_evt that captures slot bit SAMPLE_W, only in the slot matching CHANNEL.
- State machine:
  - IDLE: sck=0, ws=0, divider and bit counter held at 0. Goes to WARMUP when en=1.
  - WARMUP: sck/ws run normally, starting with ws=0. No pushes for the first 2*FRAME_BITS SCK cycles (one stereo frame), then goes to RUN.
  - RUN: pushes as above.
  - From WARMUP or RUN, en=0 returns to IDLE on the next HCLK edge. sck and ws drop to 0, the partial sample is discarded, and FIFO contents are retained. Re-enabling goes through WARMUP again.
- FIFO:
  - First-word fall-through: sample_valid is 1 one HCLK after a push into an empty FIFO.
  - A pop occurs when sample_valid and sample_ready are both 1.
  - Push while full with no pop: the new sample is dropped and overrun is set.
  - Push and pop in the same cycle while full: both are accepted, level is unchanged, no overrun.
  - Push and pop in the same cycle while empty: only the push takes effect (no pop since valid=0).
  - Pointers wrap modulo FIFO_DEPTH. fifo_level is exact and reaches FIFO_DEPTH when full.
- overrun: stays set until clr_overrun. If clr_overrun coincides with a new overrun event, overrun stays 1.

Decomposition:
- Package i2s_pkg holds:
  - state enum {IDLE, WARMUP, RUN};
  - the CLK_DIV minimum (3) as a constant;
  - slot-bit constants (DELAY_BIT=0).
- One sub-module, i2s_sample_fifo: parameterized width/depth FWFT FIFO with push/pop/level/full/empty.

Test Plan (CLK_DIV=4, FRAME_BITS=32, SAMPLE_W=24, FIFO_DEPTH=8 unless noted):
1. Assert HRESETn=0 mid-run with en=1 -> all outputs are 0 immediately (asynchronous), FIFO empty; after release with en=0, sck stays 0.
2. en=1 -> sck period = 8 HCLK; ws period = 64 SCK = 512 HCLK; every ws edge coincides with a fall_evt.
3. Mic model drives left=24'hA5C3F1, right=24'h123456 each frame:
   - CHANNEL=0: first pop after WARMUP = 24'hA5C3F1, no earlier pushes.
   - CHANNEL=1: first pop = 24'h123456.
4. sample_ready=0 for 10 frames -> fifo_level=8, overrun=1, head still equals the first sample. clr_overrun pulse -> overrun=0.
5. FIFO full, sample_ready=1 held on the push cycle -> level stays 8, overrun stays 0, data order preserved.
6. en dropped at slot bit 12 -> next HCLK sck=0, ws=0, no push, fifo_level unchanged. Re-enable -> next push only after a full WARMUP frame.

Source files
------------

// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared types and constants for the I2S receive controller
package i2s_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WARMUP,
    RUN
  } state_t;

  localparam int CLK_DIV_MIN = 3;
  localparam int DELAY_BIT   = 0;

endpackage

// File: rtl/i2s_sample_fifo.sv
// rtl/i2s_sample_fifo.sv - first-word fall-through sample FIFO with exact level
module i2s_sample_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (level == (AW+1)'(DEPTH));
  assign empty    = (level == '0);
  assign do_pop   = pop && !empty;
  // A full FIFO still accepts a push when a pop frees the head slot in the same cycle.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/i2s_rx_ctrl.sv
// rtl/i2s_rx_ctrl.sv - I2S master receiver: SCK/WS generation, single-channel capture, sample FIFO
module i2s_rx_ctrl
  import i2s_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int FRAME_BITS = 32,
  parameter int SAMPLE_W   = 24,
  parameter int FIFO_DEPTH = 8,
  parameter int CHANNEL    = 0
) (
  input  logic                          HCLK,
  input  logic                          HRESETn,
  input  logic                          en,
  input  logic                          sd,
  output logic                          sck,
  output logic                          ws,
  output logic [SAMPLE_W-1:0]           sample_data,
  output logic                          sample_valid,
  input  logic                          sample_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overrun,
  input  logic                          clr_overrun
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int BW = $clog2(FRAME_BITS);

  state_t              state;
  state_t              state_next;
  logic                sd_meta;
  logic                sd_sync;
  logic [DW-1:0]       div_cnt;
  logic [BW-1:0]       bit_cnt;
  logic [SAMPLE_W-2:0] shreg;
  logic                running;
  logic                tick;
  logic                fall_evt;
  logic                slot_end;
  logic                capture;
  logic                push;
  logic                pop;
  logic                fifo_full;
  logic                fifo_empty;

  assign running  = (state != IDLE) && en;
  assign tick     = running && (div_cnt == DW'(CLK_DIV - 1));
  assign fall_evt = tick && sck;
  assign slot_end = fall_evt && (bit_cnt == BW'(FRAME_BITS - 1));
  assign capture  = fall_evt && (bit_cnt != BW'(DELAY_BIT)) && (bit_cnt <= BW'(SAMPLE_W));
  assign push     = fall_evt && (state == RUN) && (bit_cnt == BW'(SAMPLE_W))
                    && (ws == (CHANNEL != 0));
  assign pop      = sample_valid && sample_ready;
  assign sample_valid = !fifo_empty;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sd_meta <= 1'b0;
      sd_sync <= 1'b0;
    end else begin
      sd_meta <= sd;
      sd_sync <= sd_meta;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // WARMUP ends on the falling edge that closes the right slot, i.e. after one full stereo frame.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (en) state_next = WARMUP;
      WARMUP:  if (!en) state_next = IDLE;
               else if (slot_end && ws) state_next = RUN;
      RUN:     if (!en) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      sck     <= 1'b0;
      ws      <= 1'b0;
      shreg   <= '0;
    end else if (!running) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      sck     <= 1'b0;
      ws      <= 1'b0;
      shreg   <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DW'(1);
      if (tick) begin
        sck <= !sck;
      end
      if (fall_evt) begin
        bit_cnt <= slot_end ? '0 : bit_cnt + BW'(1);
        if (slot_end) begin
          ws <= !ws;
        end
      end
      // The last sample bit goes straight to the FIFO, so the register only holds the leading bits.
      if (capture) begin
        shreg <= {shreg[SAMPLE_W-3:0], sd_sync};
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      overrun <= 1'b0;
    end else if (push && fifo_full && !pop) begin
      overrun <= 1'b1;
    end else if (clr_overrun) begin
      overrun <= 1'b0;
    end
  end

  i2s_sample_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (HCLK),
    .rst_n     (HRESETn),
    .push      (push),
    .push_data ({shreg, sd_sync}),
    .pop       (pop),
    .pop_data  (sample_data),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule
